// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
// Also provides fallback values for the global `WIDTH / `ADDR_WIDTH defines
// when the surrounding build does not set them.

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package mem_arb_pkg;

  // Sequencer states: arbitrate, hold the memory request, acknowledge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest supported number of requesters.
  localparam int MAX_REQ = 4;

  // Default number of ISSUE cycles without ready before an abort.
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Width of an encoded grant index for n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker. The requester after
// last_grant_i has highest priority, wrapping back to requester 0.

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] mask_hi;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;

  // Requesters numbered above the last winner form the preferred group.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign mask_hi[gi] = (IDX_W'(gi) > last_grant_i);
  end

  assign req_hi = req_i & mask_hi;
  assign pick   = (|req_hi) ? req_hi : req_i;

  // Lowest-numbered set bit of the chosen group wins.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt_o[gi] = (|req_i) && (idx_o == IDX_W'(gi));
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready memory port among NUM_REQ requesters.
// A winner is latched in IDLE, held on the memory port in ISSUE until ready,
// then acknowledged with a one-cycle req_ready pulse in DONE.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an ISSUE that sees
// no ready within TIMEOUT_CYCLES cycles (req_err flags the abort).

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr_rd,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*`WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           req_err,
  output logic [`WIDTH-1:0]              rsp_rdata,
  output logic                           valid,
  output logic                           wr_rd,
  output logic [`ADDR_WIDTH-1:0]         addr,
  output logic [`WIDTH-1:0]              wdata,
  input  logic                           ready,
  input  logic [`WIDTH-1:0]              rdata
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int AW    = `ADDR_WIDTH;
  localparam int DW    = `WIDTH;

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             wr_rd_q, wr_rd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  logic [AW-1:0] req_addr_arr  [NUM_REQ];
  logic [DW-1:0] req_wdata_arr [NUM_REQ];

  // Unflatten the per-requester address and write-data buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign req_wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .idx_o        (arb_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state logic: arbitration, memory wait, acknowledge.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_rd_d      = wr_rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = ISSUE;
          grant_d = arb_idx;
          wr_rd_d = |(req_wr_rd & arb_gnt);
          addr_d  = req_addr_arr[arb_idx];
          wdata_d = req_wdata_arr[arb_idx];
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (ready) begin
          // Read data is captured for writes as well.
          rsp_rdata_d  = rdata;
          last_grant_d = grant_q;
          state_d      = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Memory never answered: abort, still advancing the rotation.
          rsp_rdata_d  = '0;
          last_grant_d = grant_q;
          err_d        = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      wr_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_rd_q      <= wr_rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter and abort flag for the current transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req_err = (state_q == DONE) && err_q;
`else
  assign req_err = 1'b0;
`endif

  assign valid     = (state_q == ISSUE);
  assign wr_rd     = wr_rd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_rdata = rsp_rdata_q;

  // One-hot acknowledge to the latched winner during DONE.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign req_ready[gi] = (state_q == DONE) && (grant_q == IDX_W'(gi));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (NUM_REQ=2).
// Build with MEM_ARB_TIMEOUT_EN defined to also exercise the timeout path.

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr_rd;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic        req_err;
  logic [7:0]  rsp_rdata;
  logic        valid;
  logic        wr_rd;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  mem_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr_rd (req_wr_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .rsp_rdata (rsp_rdata),
    .valid     (valid),
    .wr_rd     (wr_rd),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of a memory that raises ready once valid has been high for
  // more than 'delay' cycles; delay < 0 means it never answers.
  task automatic mem_cycle(input int delay);
    tick();
    if (valid) begin
      vcnt++;
      if (delay >= 0 && vcnt > delay) begin
        ready = 1'b1;
        rdata = ~addr;
      end else begin
        ready = 1'b0;
      end
    end else begin
      vcnt  = 0;
      ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
    ready = 1'b0; rdata = '0;
    #2 rst = 1'b0;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if ({wr_rd, addr, wdata} !== 17'h0) begin failures++; $display("FAIL reset_mem_regs: got %h want 0", {wr_rd, addr, wdata}); end
    checks++; if ({req_ready, req_err, rsp_rdata} !== 11'h0) begin failures++; $display("FAIL reset_rsp: got %h want 0", {req_ready, req_err, rsp_rdata}); end
    rst = 1'b1;
    // A stray ready while idle must not produce anything.
    ready = 1'b1; rdata = 8'h99;
    tick();
    ready = 1'b0;
    tick();
    checks++; if ({valid, req_ready, rsp_rdata} !== 11'h0) begin failures++; $display("FAIL idle_ready_ignored: got %h want 0", {valid, req_ready, rsp_rdata}); end
    $display("TXN reset done");
  endtask

  task automatic test_reset_mid_txn();
    req_valid = 2'b01; req_wr_rd = 2'b01; req_addr = 16'h000F; req_wdata = 16'h00FF;
    tick();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mid_issue_valid: got %b want 1", valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({valid, wr_rd, addr, wdata} !== 18'h0) begin failures++; $display("FAIL mid_reset_outputs: got %h want 0", {valid, wr_rd, addr, wdata}); end
    req_valid = '0;
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_reset_no_ack: got %b want 00", req_ready); end
    rst = 1'b1;
    tick();
    $display("TXN reset during ISSUE dropped");
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; req_wr_rd = 2'b01; req_addr = 16'h0005; req_wdata = 16'h00A5;
    tick();
    checks++; if ({valid, wr_rd} !== 2'b11) begin failures++; $display("FAIL wr_c1_valid_dir: got %b want 11", {valid, wr_rd}); end
    checks++; if ({addr, wdata} !== 16'h05A5) begin failures++; $display("FAIL wr_c1_addr_data: got %h want 05a5", {addr, wdata}); end
    tick();
    checks++; if ({valid, req_ready} !== 3'b100) begin failures++; $display("FAIL wr_c2_valid: got %b want 100", {valid, req_ready}); end
    ready = 1'b1; rdata = 8'h77;
    tick();
    ready = 1'b0;
    checks++; if ({valid, req_ready} !== 3'b001) begin failures++; $display("FAIL wr_c3_ack: got %b want 001", {valid, req_ready}); end
    checks++; if (rsp_rdata !== 8'h77) begin failures++; $display("FAIL wr_rdata_capture: got %h want 77", rsp_rdata); end
    req_valid = '0;
    tick();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL wr_ack_one_cycle: got %b want 00", req_ready); end
    $display("TXN write req0 addr=05 wdata=a5");
  endtask

  task automatic test_single_read();
    req_valid = 2'b10; req_wr_rd = 2'b00; req_addr = 16'h0300; req_wdata = 16'h0;
    tick();
    checks++; if ({valid, wr_rd, addr} !== 10'h203) begin failures++; $display("FAIL rd_issue: got %h want 203", {valid, wr_rd, addr}); end
    tick();
    ready = 1'b1; rdata = 8'h3C;
    tick();
    ready = 1'b0; rdata = 8'h00;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rd_ack: got %b want 10", req_ready); end
    checks++; if ({req_err, rsp_rdata} !== 9'h03C) begin failures++; $display("FAIL rd_data_err: got %h want 03c", {req_err, rsp_rdata}); end
    req_valid = '0;
    tick();
    $display("TXN read req1 addr=03 rdata=3c");
  endtask

  task automatic test_contention();
    int acks = 0;
    int last_ack = -1;
    logic [1:0] exp_gnt;
    logic [7:0] exp_rd;
    req_valid = 2'b11; req_wr_rd = 2'b00; req_addr = 16'h2110; vcnt = 0;
    for (int t = 0; t < 40 && acks < 4; t++) begin
      mem_cycle(1);
      if (req_ready !== 2'b00) begin
        exp_gnt = (acks % 2 == 0) ? 2'b01 : 2'b10;
        exp_rd  = (acks % 2 == 0) ? 8'hEF : 8'hDE;
        checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL rr_order%0d: got %b want %b", acks, req_ready, exp_gnt); end
        checks++; if (rsp_rdata !== exp_rd) begin failures++; $display("FAIL rr_rdata%0d: got %h want %h", acks, rsp_rdata, exp_rd); end
        checks++;
        if (acks == 0) begin
          if (t != 2) begin failures++; $display("FAIL rr_first_latency: got %0d want 2", t); end
        end else if (t - last_ack != 4) begin
          failures++; $display("FAIL rr_spacing%0d: got %0d want 4", acks, t - last_ack);
        end
        $display("TXN contention ack=%b rdata=%h t=%0d", req_ready, rsp_rdata, t);
        last_ack = t;
        acks++;
        if (acks == 4) req_valid = '0;
      end
    end
    checks++; if (acks != 4) begin failures++; $display("FAIL rr_ack_count: got %0d want 4", acks); end
    mem_cycle(1);
  endtask

  task automatic test_slow_memory();
    int ready_t = -1;
    int ack_t = -1;
    req_valid = 2'b01; req_wr_rd = 2'b01; req_addr = 16'h0007; req_wdata = 16'h005A; vcnt = 0;
    for (int t = 0; t < 30 && ack_t < 0; t++) begin
      mem_cycle(5);
      if (req_ready !== 2'b00) begin
        ack_t = t;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL slow_ack: got %b want 01", req_ready); end
        req_valid = '0;
      end else begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL slow_valid_held t=%0d: got %b want 1", t, valid); end
        if (ready && ready_t < 0) ready_t = t;
      end
    end
    checks++; if (ack_t != 6) begin failures++; $display("FAIL slow_ack_time: got %0d want 6", ack_t); end
    checks++; if (ready_t != 5) begin failures++; $display("FAIL slow_ready_time: got %0d want 5", ready_t); end
    $display("TXN slow write req0 ready_t=%0d ack_t=%0d", ready_t, ack_t);
    mem_cycle(5);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int ack_t = -1;
    req_valid = 2'b01; req_wr_rd = 2'b00; req_addr = 16'h0009; vcnt = 0;
    for (int t = 0; t < 20 && ack_t < 0; t++) begin
      mem_cycle(-1);
      if (req_ready !== 2'b00) begin
        ack_t = t;
        checks++; if ({req_ready, req_err} !== 3'b011) begin failures++; $display("FAIL to_ack_err: got %b want 011", {req_ready, req_err}); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL to_rdata: got %h want 00", rsp_rdata); end
        req_valid = '0;
      end
    end
    checks++; if (ack_t != 4) begin failures++; $display("FAIL to_time: got %0d want 4", ack_t); end
    $display("TXN timeout req0 ack_t=%0d", ack_t);
    mem_cycle(-1);
    ack_t = -1;
    req_valid = 2'b10; req_addr = 16'h4400; vcnt = 0;
    for (int t = 0; t < 20 && ack_t < 0; t++) begin
      mem_cycle(1);
      if (req_ready !== 2'b00) begin
        ack_t = t;
        checks++; if ({req_ready, req_err} !== 3'b100) begin failures++; $display("FAIL to_next_ack: got %b want 100", {req_ready, req_err}); end
        checks++; if (rsp_rdata !== 8'hBB) begin failures++; $display("FAIL to_next_rdata: got %h want bb", rsp_rdata); end
        req_valid = '0;
      end
    end
    checks++; if (ack_t != 2) begin failures++; $display("FAIL to_next_time: got %0d want 2", ack_t); end
    $display("TXN after timeout req1 ack_t=%0d", ack_t);
    mem_cycle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_txn();
    test_single_write();
    test_single_read();
    test_contention();
    test_slow_memory();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
